// File: rtl/gsim_mem_fetch_ctrl_if.sv
// Memory read bus and row-stream bus between the GSIM fetch controller (master)
// and its environment: matrix memory plus solver core (slave).
interface gsim_mem_fetch_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 256
);
    logic              mem_rreq;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rrdy;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_dout_vld;

    logic              row_vld;
    logic              row_rdy;
    logic [DATA_W-1:0] row_data;
    logic [4:0]        row_mat;
    logic [4:0]        row_idx;
    logic              row_last;

    modport master (
        output mem_rreq, mem_addr,
        input  mem_rrdy, mem_dout, mem_dout_vld,
        output row_vld, row_data, row_mat, row_idx, row_last,
        input  row_rdy
    );

    modport slave (
        input  mem_rreq, mem_addr,
        output mem_rrdy, mem_dout, mem_dout_vld,
        input  row_vld, row_data, row_mat, row_idx, row_last,
        output row_rdy
    );
endinterface

// File: rtl/gsim_mem_fetch_ctrl.sv
// Credit-limited read scheduler feeding tagged matrix words to the GSIM solver core.
// Optional GSIM_FETCH_PERF_EN adds a saturating stall counter output (stall_cnt).
module gsim_mem_fetch_ctrl #(
    parameter int MAT_WORDS  = 17,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [4:0]                    matrix_num,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    gsim_mem_fetch_ctrl_if.master         bus
`ifdef GSIM_FETCH_PERF_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] total_reg, start_total;
    logic              rreq_reg, rreq_next;
    logic [CW-1:0]     out_reg, out_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [CW:0]       credit_sum;
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [4:0]        ret_mat_reg, ret_row_reg;
    logic              err_reg;

    logic              start_acc, accept, push, pop, row_vld;

    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [4:0]        mat_mem  [FIFO_DEPTH];
    logic [4:0]        row_mem  [FIFO_DEPTH];

    assign start_acc   = (state_reg == S_IDLE) && start;
    assign accept      = rreq_reg && bus.mem_rrdy;
    // Returns with nothing outstanding are stray beats: dropped and flagged.
    assign push        = bus.mem_dout_vld && (out_reg != '0);
    assign row_vld     = (cnt_reg != '0);
    assign pop         = row_vld && bus.row_rdy;
    assign start_total = ADDR_W'(32'(matrix_num) * MAT_WORDS);

    assign out_next    = out_reg + CW'(accept) - CW'(push);
    assign cnt_next    = cnt_reg + CW'(push) - CW'(pop);
    assign addr_next   = start_acc ? '0 : addr_reg + ADDR_W'(accept);
    assign credit_sum  = {1'b0, out_next} + {1'b0, cnt_next};

    always_comb begin
        state_next = state_reg;
        rreq_next  = 1'b0;
        case (state_reg)
            S_IDLE:  if (start) state_next = (matrix_num == 5'd0) ? S_DONE : S_FETCH;
            S_FETCH: if (addr_next == total_reg) state_next = S_DRAIN;
            S_DRAIN: if (out_next == '0 && cnt_next == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // Request is registered, so grant it from next-cycle credit state.
        if (state_next == S_FETCH && credit_sum < (CW+1)'(FIFO_DEPTH))
            rreq_next = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            addr_reg    <= '0;
            total_reg   <= '0;
            rreq_reg    <= 1'b0;
            out_reg     <= '0;
            cnt_reg     <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            ret_mat_reg <= '0;
            ret_row_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            rreq_reg  <= rreq_next;
            out_reg   <= out_next;
            cnt_reg   <= cnt_next;
            if (start_acc) total_reg <= start_total;
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (start_acc) begin
                ret_mat_reg <= '0;
                ret_row_reg <= '0;
            end else if (push) begin
                if (ret_row_reg == 5'(MAT_WORDS - 1)) begin
                    ret_row_reg <= '0;
                    ret_mat_reg <= ret_mat_reg + 5'd1;
                end else begin
                    ret_row_reg <= ret_row_reg + 5'd1;
                end
            end
            if (start_acc)
                err_reg <= 1'b0;
            else if (bus.mem_dout_vld && out_reg == '0)
                err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= bus.mem_dout;
            mat_mem[wr_ptr_reg]  <= ret_mat_reg;
            row_mem[wr_ptr_reg]  <= ret_row_reg;
        end
    end

    // Head outputs are forced to zero while empty so reset/idle values are clean.
    assign bus.row_vld  = row_vld;
    assign bus.row_data = row_vld ? data_mem[rd_ptr_reg] : '0;
    assign bus.row_mat  = row_vld ? mat_mem[rd_ptr_reg] : 5'd0;
    assign bus.row_idx  = row_vld ? row_mem[rd_ptr_reg] : 5'd0;
    assign bus.row_last = row_vld && (row_mem[rd_ptr_reg] == 5'(MAT_WORDS - 1));
    assign bus.mem_rreq = rreq_reg;
    assign bus.mem_addr = addr_reg;

    assign busy = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
    assign done = (state_reg == S_DONE);
    assign err  = err_reg;

`ifdef GSIM_FETCH_PERF_EN
    logic [15:0] stall_reg;
    logic [1:0]  stall_inc;
    logic [16:0] stall_sum;

    assign stall_inc = 2'(state_reg == S_FETCH && rreq_reg && !bus.mem_rrdy)
                     + 2'(row_vld && !bus.row_rdy);
    assign stall_sum = {1'b0, stall_reg} + 17'(stall_inc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_reg <= '0;
        else if (start_acc)
            stall_reg <= '0;
        else
            stall_reg <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end

    assign stall_cnt = stall_reg;
`endif
endmodule

// File: tb/tb_gsim_mem_fetch_ctrl.sv
// Directed bench for gsim_mem_fetch_ctrl: latency-1 memory model, in-order pop checking.
`timescale 1ns/1ps
module tb_gsim_mem_fetch_ctrl;
    localparam int MW    = 17;
    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int DW    = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] matrix_num = 5'd0;
    logic       busy, done, err;
    logic       inject_vld = 1'b0;
    logic       mem_vld_q;
    logic [DW-1:0] mem_dout_q;
`ifdef GSIM_FETCH_PERF_EN
    logic [15:0] stall_cnt;
    int          stall_exp;
`endif

    int checks = 0, failures = 0;
    int cyc, pops, reqs, done_seen, err_seen, busy_seen, done_cyc, last_pop_cyc, last_addr;
    logic busy_at_done;

    gsim_mem_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

    gsim_mem_fetch_ctrl #(
        .MAT_WORDS(MW), .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .matrix_num(matrix_num),
        .busy(busy),
        .done(done),
        .err(err),
        .bus(mif)
`ifdef GSIM_FETCH_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(input int a);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++)
            d[k*32 +: 32] = 32'(a) * 32'h9E3779B1 + 32'(k * 7 + 1);
        return d;
    endfunction

    // Memory: every accepted request returns its word exactly one cycle later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_vld_q  <= 1'b0;
            mem_dout_q <= '0;
        end else begin
            mem_vld_q  <= mif.mem_rreq && mif.mem_rrdy;
            mem_dout_q <= data_of(int'(mif.mem_addr));
        end
    end
    assign mif.mem_dout_vld = mem_vld_q | inject_vld;
    assign mif.mem_dout     = mem_dout_q;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: drive ready inputs, check this cycle's transfers, advance.
    task automatic step(input bit rr, input bit rd);
        mif.mem_rrdy = rr;
        mif.row_rdy  = rd;
        if (mif.mem_rreq && rr) begin
            chk("req_addr", 256'(mif.mem_addr), 256'(reqs));
            last_addr = int'(mif.mem_addr);
            reqs++;
        end
        if (mif.row_vld && rd) begin
            chk("row_data", mif.row_data, data_of(pops));
            chk("row_mat", 256'(mif.row_mat), 256'(pops / MW));
            chk("row_idx", 256'(mif.row_idx), 256'(pops % MW));
            chk("row_last", 256'(mif.row_last), 256'((pops % MW) == MW - 1));
            pops++;
            last_pop_cyc = cyc;
        end
        if (done) begin
            done_seen++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
        if (busy) busy_seen++;
        if (err) err_seen++;
`ifdef GSIM_FETCH_PERF_EN
        stall_exp += int'(mif.mem_rreq && !rr) + int'(mif.row_vld && !rd);
`endif
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_fetch(input int n, input bit rnd, input int hold, input int abort_at,
                             input int budget);
        int total;
        total = n * MW;
        cyc = 0; pops = 0; reqs = 0; done_seen = 0; err_seen = 0; busy_seen = 0;
        done_cyc = -1; last_pop_cyc = -1; last_addr = -1; busy_at_done = 1'b0;
        start = 1'b1;
        matrix_num = 5'(n);
        mif.mem_rrdy = 1'b1;
        mif.row_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef GSIM_FETCH_PERF_EN
        stall_exp = 0;
`endif
        for (int h = 0; h < hold; h++) begin
            start = (h == 2);
            matrix_num = (h == 2) ? 5'd7 : 5'(n);
            step(1'b1, 1'b0);
        end
        start = 1'b0;
        if (hold > 0) begin
            chk("hold_reqs", 256'(reqs), 256'((total < DEPTH) ? total : DEPTH));
            chk("hold_rreq", 256'(mif.mem_rreq), 256'(0));
        end
        while (done_seen == 0 && cyc < budget && !(abort_at > 0 && pops >= abort_at)) begin
            if (rnd) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else     step(1'b1, 1'b1);
        end
        if (abort_at > 0) return;
        chk("done_seen", 256'(done_seen), 256'(1));
        chk("pops", 256'(pops), 256'(total));
        chk("reqs", 256'(reqs), 256'(total));
        chk("err_seen", 256'(err_seen), 256'(0));
        chk("busy_at_done", 256'(busy_at_done), 256'(0));
        if (n > 0) begin
            chk("done_latency", 256'(done_cyc), 256'(last_pop_cyc + 1));
            chk("last_addr", 256'(last_addr), 256'(total - 1));
        end else begin
            chk("done_latency", 256'(done_cyc), 256'(0));
            chk("busy_seen", 256'(busy_seen), 256'(0));
        end
        chk("done_pulse", 256'(done), 256'(0));
        chk("idle_rreq", 256'(mif.mem_rreq), 256'(0));
`ifdef GSIM_FETCH_PERF_EN
        chk("stall_cnt", 256'(stall_cnt), 256'(stall_exp));
`endif
    endtask

    task automatic chk_zero_outputs(input string phase);
        chk({phase, "_busy"}, 256'(busy), 256'(0));
        chk({phase, "_done"}, 256'(done), 256'(0));
        chk({phase, "_err"}, 256'(err), 256'(0));
        chk({phase, "_rreq"}, 256'(mif.mem_rreq), 256'(0));
        chk({phase, "_addr"}, 256'(mif.mem_addr), 256'(0));
        chk({phase, "_row_vld"}, 256'(mif.row_vld), 256'(0));
        chk({phase, "_row_data"}, mif.row_data, 256'(0));
        chk({phase, "_row_mat"}, 256'(mif.row_mat), 256'(0));
        chk({phase, "_row_idx"}, 256'(mif.row_idx), 256'(0));
        chk({phase, "_row_last"}, 256'(mif.row_last), 256'(0));
    endtask

    initial begin
        mif.mem_rrdy = 1'b0;
        mif.row_rdy  = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single matrix, full throughput.
        run_fetch(1, 1'b0, 0, 0, 200);
        @(negedge clk);

        // Zero matrices: immediate done, never busy.
        run_fetch(0, 1'b0, 0, 0, 20);
        @(negedge clk);

        // Consumer stalled: credits cap requests at FIFO depth; restart mid-fetch ignored.
        run_fetch(2, 1'b0, 20, 0, 400);
        @(negedge clk);

        // Full address space with random back-pressure on both sides.
        run_fetch(31, 1'b1, 0, 0, 20000);
        @(negedge clk);

        // Stray return beat while idle sets the sticky error; the next start clears it.
        inject_vld = 1'b1;
        @(negedge clk);
        inject_vld = 1'b0;
        @(negedge clk);
        chk("err_set", 256'(err), 256'(1));
        @(negedge clk);
        chk("err_sticky", 256'(err), 256'(1));
        run_fetch(1, 1'b0, 0, 0, 200);
        @(negedge clk);

        // Reset in the middle of a 3-matrix fetch, then a clean restart.
        run_fetch(3, 1'b0, 0, 8, 400);
        chk("abort_pops", 256'(pops), 256'(8));
        reset = 1'b1;
        #1;
        chk_zero_outputs("abort");
        @(negedge clk);
        chk("abort_rreq_hold", 256'(mif.mem_rreq), 256'(0));
        chk("abort_vld_hold", 256'(mif.row_vld), 256'(0));
        reset = 1'b0;
        @(negedge clk);
        run_fetch(1, 1'b0, 8, 0, 300);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
